// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, functs, ALU ops,
// PC source select and FSM state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [2:0] PC_INC = 3'd0;
  localparam logic [2:0] PC_BR  = 3'd1;
  localparam logic [2:0] PC_J   = 3'd2;
  localparam logic [2:0] PC_JR  = 3'd3;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_TRAP   = 3'd6;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port handshake between the controller and the memory arbiter.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel_data;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_sel_data, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_sel_data, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational opcode/funct -> ALU op map with an illegal-instruction flag.
module alu_op_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_JR:   alu_op = ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu_op = ALU_ADD;
      OP_ORI:                alu_op = ALU_OR;
      OP_BEQ, OP_BNE:        alu_op = ALU_SUB;
      OP_J:                  alu_op = ALU_ADD;
      default:               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout.
// Optional perf counters when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              alu_zero,
  multicycle_ctrl_if.master mem,
  output logic              ir_wren,
  output logic              pc_wren,
  output logic [2:0]        pc_control,
  output logic              reg_file_wren,
  output logic              reg_file_dmux_sel,
  output logic              reg_file_rmux_sel,
  output logic              alu_mux_sel,
  output logic [3:0]        alu_op,
  output logic              busy,
  output logic              trap
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_instret
`endif
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t     state, nxt;
  logic [5:0] op_q, fn_q;
  logic [7:0] wait_cnt;
  logic [5:0] dec_op, dec_fn;
  logic [3:0] dec_aop;
  logic       dec_ill;
  logic       is_r, is_jr, is_imm, timeout;

  // One decoder serves both phases: live inputs in DECODE, latched fields after.
  assign dec_op = (state == S_DECODE) ? opcode : op_q;
  assign dec_fn = (state == S_DECODE) ? funct  : fn_q;

  alu_op_decode u_dec (
    .opcode  (dec_op),
    .funct   (dec_fn),
    .alu_op  (dec_aop),
    .illegal (dec_ill)
  );

  assign is_r    = (op_q == OP_R);
  assign is_jr   = is_r && (fn_q == FN_JR);
  assign is_imm  = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI) || (op_q == OP_ORI);
  assign timeout = (MAX_WAIT != 0) && (wait_cnt == MAX_W) && !mem.mem_ready;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (mem.mem_ready) nxt = S_DECODE;
                else if (timeout) nxt = S_TRAP;
      S_DECODE: nxt = dec_ill ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_R:                 nxt = is_jr ? S_FETCH : S_WB;
          OP_LW, OP_SW:         nxt = S_MEM;
          OP_ADDI, OP_ORI:      nxt = S_WB;
          default:              nxt = S_FETCH;
        endcase
      end
      S_MEM:    if (mem.mem_ready) nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
                else if (timeout) nxt = S_TRAP;
      S_WB:     nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      fn_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (nxt != state)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Moore outputs; only the FETCH write strobes look at mem_ready.
  always_comb begin
    mem.mem_req       = 1'b0;
    mem.mem_we        = 1'b0;
    mem.mem_sel_data  = 1'b0;
    ir_wren           = 1'b0;
    pc_wren           = 1'b0;
    pc_control        = PC_INC;
    reg_file_wren     = 1'b0;
    reg_file_dmux_sel = 1'b0;
    reg_file_rmux_sel = 1'b0;
    alu_mux_sel       = 1'b0;
    alu_op            = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_wren     = mem.mem_ready;
        pc_wren     = mem.mem_ready;
      end
      S_EXEC: begin
        alu_op      = dec_aop;
        alu_mux_sel = is_imm;
        case (op_q)
          OP_BEQ: begin pc_control = PC_BR; pc_wren = alu_zero;  end
          OP_BNE: begin pc_control = PC_BR; pc_wren = !alu_zero; end
          OP_J:   begin pc_control = PC_J;  pc_wren = 1'b1;      end
          OP_R:   if (is_jr) begin pc_control = PC_JR; pc_wren = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_sel_data = 1'b1;
        mem.mem_we       = (op_q == OP_SW);
      end
      S_WB: begin
        reg_file_wren     = 1'b1;
        reg_file_rmux_sel = is_r;
        reg_file_dmux_sel = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_TRAP);
  assign trap = (state == S_TRAP);

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles  <= '0;
      perf_instret <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if (nxt == S_FETCH && (state == S_EXEC || state == S_MEM || state == S_WB))
        perf_instret <= perf_instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: table vectors, random instruction stream against a
// phase-level timeline model, plus trap/timeout/reset corner sequences.
module tb_multicycle_ctrl;
  import cpu_pkg::*;

  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       ir_wren, pc_wren, reg_file_wren, reg_file_dmux_sel, reg_file_rmux_sel;
  logic       alu_mux_sel, busy, trap;
  logic [2:0] pc_control;
  logic [3:0] alu_op;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_instret;
`endif

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MAX_WAIT(MW)) dut (
    .clk               (clk),
    .rst               (rst),
    .opcode            (opcode),
    .funct             (funct),
    .alu_zero          (alu_zero),
    .mem               (bus),
    .ir_wren           (ir_wren),
    .pc_wren           (pc_wren),
    .pc_control        (pc_control),
    .reg_file_wren     (reg_file_wren),
    .reg_file_dmux_sel (reg_file_dmux_sel),
    .reg_file_rmux_sel (reg_file_rmux_sel),
    .alu_mux_sel       (alu_mux_sel),
    .alu_op            (alu_op),
    .busy              (busy),
    .trap              (trap)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .perf_cycles       (perf_cycles),
    .perf_instret      (perf_instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, sel, ir, pcw;
    logic [2:0] pcc;
    logic       rfw, dmux, rmux, amux;
    logic [3:0] aop;
    logic       busy, trap;
  } outs_t;

  typedef enum {C_R, C_JR, C_LW, C_SW, C_ADDI, C_ORI, C_BEQ, C_BNE, C_J, C_BAD} cls_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z;
    int         wf, wm, cyc;
    string      nm;
  } vec_t;

  outs_t sched[$];
  bit    care[$];
  int    n_chk = 0, n_fail = 0;
  int    exp_busy = 0, exp_ret = 0;

  function automatic outs_t sample();
    outs_t o;
    o.req = bus.mem_req; o.we = bus.mem_we; o.sel = bus.mem_sel_data;
    o.ir = ir_wren; o.pcw = pc_wren; o.pcc = pc_control;
    o.rfw = reg_file_wren; o.dmux = reg_file_dmux_sel; o.rmux = reg_file_rmux_sel;
    o.amux = alu_mux_sel; o.aop = alu_op; o.busy = busy; o.trap = trap;
    return o;
  endfunction

  // Fields that only carry meaning alongside their strobe are zeroed otherwise.
  function automatic outs_t mask(outs_t o, bit c);
    if (!o.pcw) o.pcc = '0;
    if (!o.rfw) begin o.dmux = 1'b0; o.rmux = 1'b0; end
    if (!o.req) begin o.we = 1'b0; o.sel = 1'b0; end
    if (!c) begin o.aop = '0; o.amux = 1'b0; end
    return o;
  endfunction

  task automatic check_outs(input string nm, input outs_t act, input outs_t exp, input bit c);
    outs_t a, e;
    a = mask(act, c);
    e = mask(exp, c);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (req we sel ir pcw pcc rfw dmux rmux amux aop busy trap)", nm, a, e);
    end
  endtask

  task automatic check_int(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic cls_t classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      OP_R: begin
        if (fn == FN_JR) return C_JR;
        if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT) return C_R;
        return C_BAD;
      end
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_ADDI: return C_ADDI;
      OP_ORI:  return C_ORI;
      OP_BEQ:  return C_BEQ;
      OP_BNE:  return C_BNE;
      OP_J:    return C_J;
      default: return C_BAD;
    endcase
  endfunction

  function automatic logic [3:0] funct_op(logic [5:0] fn);
    case (fn)
      FN_SUB:  return 4'd1;
      FN_AND:  return 4'd2;
      FN_OR:   return 4'd3;
      FN_SLT:  return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  function automatic outs_t busy_o();
    outs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t trap_o();
    outs_t o = '0;
    o.trap = 1'b1;
    return o;
  endfunction

  task automatic push(input outs_t o, input bit c);
    sched.push_back(o);
    care.push_back(c);
  endtask

  // Memory phase of w wait cycles; returns 1 if the wait limit traps it.
  task automatic mem_phase(input bit data, input bit wr, input int w, output bit trapped);
    outs_t o = busy_o();
    o.req = 1'b1; o.sel = data; o.we = wr;
    trapped = (w > MW);
    for (int i = 0; i < (trapped ? MW + 1 : w); i++) push(o, 1'b0);
    if (trapped) begin
      for (int i = 0; i < 10; i++) push(trap_o(), 1'b1);
    end else begin
      if (!data) begin o.ir = 1'b1; o.pcw = 1'b1; end
      push(o, 1'b0);
    end
  endtask

  task automatic build(input logic [5:0] op, fn, input logic z, input int wf, wm, output bit hang);
    cls_t  c = classify(op, fn);
    outs_t o;
    bit    t;
    sched.delete(); care.delete();
    mem_phase(1'b0, 1'b0, wf, t);
    hang = t;
    if (t) return;
    push(busy_o(), 1'b0);
    if (c == C_BAD) begin
      for (int i = 0; i < 20; i++) push(trap_o(), 1'b1);
      hang = 1'b1;
      return;
    end
    o = busy_o();
    case (c)
      C_R:                o.aop = funct_op(fn);
      C_LW, C_SW, C_ADDI: o.amux = 1'b1;
      C_ORI:              begin o.amux = 1'b1; o.aop = 4'd3; end
      C_BEQ:              begin o.aop = 4'd1; o.pcw = z;  o.pcc = 3'd1; end
      C_BNE:              begin o.aop = 4'd1; o.pcw = !z; o.pcc = 3'd1; end
      C_J:                begin o.pcw = 1'b1; o.pcc = 3'd2; end
      C_JR:               begin o.pcw = 1'b1; o.pcc = 3'd3; end
      default: ;
    endcase
    push(o, 1'b1);
    if (c == C_LW || c == C_SW) begin
      mem_phase(1'b1, c == C_SW, wm, t);
      hang = t;
      if (t) return;
    end
    if (c == C_R || c == C_LW || c == C_ADDI || c == C_ORI) begin
      o = busy_o();
      o.rfw = 1'b1; o.rmux = (c == C_R); o.dmux = (c == C_LW);
      push(o, 1'b0);
    end
  endtask

  // Entered and left just after a falling edge with the DUT in FETCH.
  task automatic run(input logic [5:0] op, fn, input logic z, input int wf, wm, exp_cyc, input string nm);
    bit   hang, done, left;
    int   n, wcnt;
    logic preq, psel;
    build(op, fn, z, wf, wm, hang);
    n = 0; wcnt = 0; done = 0; left = 0; preq = 0; psel = 0;
    alu_zero = z;
    while (!done) begin
      opcode = (n <= wf + 1) ? op : 6'($urandom);
      funct  = (n <= wf + 1) ? fn : 6'($urandom);
      if (bus.mem_req) begin
        if (!preq || psel != bus.mem_sel_data) wcnt = 0;
        bus.mem_ready = (wcnt >= (bus.mem_sel_data ? wm : wf));
        wcnt++;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      preq = bus.mem_req; psel = bus.mem_sel_data;
      #1;
      if (n < sched.size()) check_outs($sformatf("%s_c%0d", nm, n), sample(), sched[n], care[n]);
      n++;
      @(negedge clk);
      if (hang) done = (n >= sched.size());
      else if (!(bus.mem_req && !bus.mem_sel_data)) left = 1;
      else if (left) done = 1;
      if (!done && n > 60) begin
        check_int({nm, "_timeout"}, n, exp_cyc);
        done = 1;
      end
    end
    if (!hang) begin
      check_int({nm, "_cycles"}, n, exp_cyc);
      exp_busy += n;
      exp_ret++;
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1 check_outs({nm, "_during"}, sample(), '0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1 check_outs({nm, "_idle"}, sample(), '0, 1'b1);
    @(negedge clk);
    exp_busy = 0; exp_ret = 0;
  endtask

  function automatic int base_cyc(cls_t c);
    case (c)
      C_R, C_ADDI, C_ORI, C_SW: return 4;
      C_LW:                     return 5;
      default:                  return 3;
    endcase
  endfunction

  initial begin
    vec_t       tbl[$];
    logic [5:0] rops[10];
    logic [5:0] rfns[10];
    outs_t      o;

    tbl.push_back('{OP_R,    FN_ADD, 1'b0, 0, 0, 4, "add"});
    tbl.push_back('{OP_R,    FN_SUB, 1'b0, 1, 0, 5, "sub_wf1"});
    tbl.push_back('{OP_R,    FN_AND, 1'b1, 0, 0, 4, "and"});
    tbl.push_back('{OP_R,    FN_OR,  1'b0, 0, 0, 4, "or"});
    tbl.push_back('{OP_R,    FN_SLT, 1'b0, 2, 0, 6, "slt_wf2"});
    tbl.push_back('{OP_ADDI, 6'h15,  1'b0, 0, 0, 4, "addi"});
    tbl.push_back('{OP_ORI,  6'h00,  1'b0, 0, 0, 4, "ori"});
    tbl.push_back('{OP_LW,   6'h00,  1'b0, 0, 3, 8, "lw_wm3"});
    tbl.push_back('{OP_LW,   6'h00,  1'b0, 0, 4, 9, "lw_wm4_edge"});
    tbl.push_back('{OP_SW,   6'h00,  1'b0, 0, 1, 5, "sw_wm1"});
    tbl.push_back('{OP_BEQ,  6'h00,  1'b1, 0, 0, 3, "beq_taken"});
    tbl.push_back('{OP_BEQ,  6'h00,  1'b0, 0, 0, 3, "beq_not"});
    tbl.push_back('{OP_BNE,  6'h00,  1'b0, 0, 0, 3, "bne_taken"});
    tbl.push_back('{OP_BNE,  6'h00,  1'b1, 0, 0, 3, "bne_not"});
    tbl.push_back('{OP_J,    6'h00,  1'b0, 0, 0, 3, "j"});
    tbl.push_back('{OP_R,    FN_JR,  1'b0, 0, 0, 3, "jr"});
    tbl.push_back('{OP_R,    FN_ADD, 1'b0, 4, 0, 8, "fetch_wf4_edge"});

    rops = '{OP_R, OP_R, OP_R, OP_R, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE};
    rfns = '{FN_ADD, FN_SLT, FN_JR, FN_AND, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0};

    bus.mem_ready = 1'b0;
    #2 check_outs("reset_state", sample(), '0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1 check_outs("first_idle", sample(), '0, 1'b1);
    @(negedge clk);

    foreach (tbl[i])
      run(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].wf, tbl[i].wm, tbl[i].cyc, tbl[i].nm);

    for (int i = 0; i < 30; i++) begin
      int   k, wf, wm;
      cls_t c;
      k  = $urandom_range(0, 9);
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      c  = classify(rops[k], rfns[k]);
      if (rops[k] == OP_J) c = C_J;
      run(rops[k], rfns[k], 1'($urandom), wf, wm,
          base_cyc(c) + wf + ((c == C_LW || c == C_SW) ? wm : 0), $sformatf("rnd%0d", i));
    end
    run(OP_J, 6'h0, 1'b0, 1, 0, 4, "j_wf1");

`ifdef MULTICYCLE_CTRL_PERF_EN
    check_int("perf_cycles", perf_cycles, exp_busy);
    check_int("perf_instret", perf_instret, exp_ret);
`endif

    run(6'b111111, 6'h0, 1'b0, 0, 0, 0, "illegal_op");
    do_reset("trap_clear");
    run(OP_R, 6'b111111, 1'b0, 0, 0, 0, "illegal_funct");
    do_reset("trap_clear2");
    run(OP_ADDI, 6'h0, 1'b0, 99, 0, 0, "fetch_timeout");
    do_reset("trap_clear3");
    run(OP_LW, 6'h0, 1'b0, 0, 99, 0, "mem_timeout");
    do_reset("trap_clear4");

    // SW aborted by reset while its memory request is outstanding
    opcode = OP_SW; funct = 6'h0; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    o = busy_o(); o.req = 1'b1; o.sel = 1'b1; o.we = 1'b1;
    #1 check_outs("sw_mem", sample(), o, 1'b0);
    #2 rst = 1'b1;
    #1 check_outs("sw_abort", sample(), '0, 1'b1);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_int("perf_cycles_rst", perf_cycles, 0);
    check_int("perf_instret_rst", perf_instret, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1 check_outs("post_abort_idle", sample(), '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencing controller for the CPU datapath. It replaces single-cycle decode with a registered FSM that steps each instruction through fetch, decode, execute, memory and write-back. It issues the datapath strobes (PC, register file, ALU, data memory) one phase at a time and stalls on a req/ready handshake toward a shared, variable-latency memory port. The block sits between the instruction register/ALU flags and the datapath mux/write-enable inputs.

## Interface
Parameters:
- `MAX_WAIT`, default 255: memory wait-cycle limit before a bus-timeout trap; 0 disables the limit.

Ports (all synchronous to `clk`):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: `instr[31:26]`, sampled in DECODE.
- `funct` in 6: `instr[5:0]`, sampled in DECODE.
- `alu_zero` in 1: ALU zero flag, sampled in EXEC.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: write qualifier for `mem_req` (stores only).
- `mem_sel_data` out 1: 0 = instruction address (PC), 1 = data address (ALU result).
- `ir_wren` out 1: load the instruction register.
- `pc_wren` out 1: update PC using `pc_control`.
- `pc_control` out 3: 0 = PC+4, 1 = branch, 2 = jump, 3 = jump-register.
- `reg_file_wren` out 1: register file write.
- `reg_file_dmux_sel` out 1: 0 = ALU result, 1 = memory data.
- `reg_file_rmux_sel` out 1: 0 = `rt` destination, 1 = `rd` destination.
- `alu_mux_sel` out 1: 0 = register source, 1 = sign-extended immediate.
- `alu_op` out 4: ALU operation.
- `busy` out 1: high in every state except IDLE and TRAP.
- `trap` out 1: sticky; high on illegal opcode or bus timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding is held in the state register.
- **IDLE**: entered on reset. All outputs are 0. Advances to FETCH unconditionally on the next clock edge.
- **FETCH**:
  - Drives `mem_req=1`, `mem_sel_data=0`.
  - On `mem_ready`: pulses `ir_wren` and `pc_wren` (`pc_control=0`), then goes to DECODE.
  - Otherwise holds FETCH and increments the wait counter.
- **DECODE**: latches `opcode` and `funct` into internal registers. Unknown opcode, or R-type with unknown funct, goes to TRAP; otherwise goes to EXEC.
- **EXEC** (driven from the latched opcode):
  - R-type: `alu_mux_sel=0`, `alu_op` from funct, then WB.
  - LW/SW/ADDI: `alu_mux_sel=1`, ADD. LW/SW go to MEM; ADDI goes to WB.
  - ORI: `alu_mux_sel=1`, OR, then WB.
  - BEQ: SUB. Pulses `pc_wren` with `pc_control=1` only when `alu_zero=1`, then FETCH.
  - BNE: the same, but pulses only when `alu_zero=0`.
  - J: `pc_wren`, `pc_control=2`, then FETCH.
  - JR (R-type, funct 001000): `pc_wren`, `pc_control=3`, then FETCH. JR does no register write.
- **MEM**:
  - Drives `mem_req=1`, `mem_sel_data=1`; `mem_we=1` for SW.
  - On `mem_ready`: LW goes to WB, SW goes to FETCH.
  - Otherwise holds MEM.
- **WB**:
  - Pulses `reg_file_wren`.
  - `reg_file_rmux_sel=1` for R-type, 0 otherwise. `reg_file_dmux_sel=1` for LW only.
  - Goes to FETCH.
- **Wait counter**: 8 bits wide; clears on every state change. When `MAX_WAIT != 0` and the counter reaches `MAX_WAIT` while `mem_ready=0`, go to TRAP and drop `mem_req` on the next cycle.
- **TRAP**: all strobes 0, `trap=1`. Held until `rst`.
- While `mem_req=1`, the values of `mem_we` and `mem_sel_data` do not change.

## Timing
- Outputs are decoded from the registered state and latched opcode only (Moore); no output depends combinationally on `mem_ready`. The exception is `ir_wren`/`pc_wren` in FETCH, which are qualified by `mem_ready` within the same cycle.
- With zero-wait memory (`mem_ready` held at 1), from the first FETCH cycle to the next FETCH:
  - R-type, ADDI, ORI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE, J, JR: 3 cycles.
- Each cycle with `mem_ready=0` adds exactly one cycle.
- Asserting `rst` in any state forces IDLE immediately (asynchronously), clears `trap`, the latched opcode and funct, and the wait counter, and aborts any outstanding `mem_req` in the same cycle.

## Configuration
- **`MULTICYCLE_CTRL_PERF_EN` defined**:
  - Adds `perf_cycles` out 32: counts every non-IDLE, non-TRAP cycle.
  - Adds `perf_instret` out 32: increments on each transition into FETCH from EXEC, MEM or WB.
  - Both counters are cleared by `rst` and wrap modulo 2^32.
- **Not defined**: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `cpu_pkg` holds:
  - Opcode constants: R 000000, J 000010, BEQ 000100, BNE 000101, ADDI 001000, ORI 001101, LW 100011, SW 101011.
  - Funct constants: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, JR 001000.
  - ALU op encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
  - `pc_control` encoding.
  - State typedef.
- One sub-module, `alu_op_decode`: combinational mapping of opcode/funct to `alu_op` plus an illegal flag, reused by DECODE and EXEC.

## Test plan
- Reset, then `mem_ready=1` and an ADD R-type -> states IDLE, F, D, E, WB, F; `reg_file_wren` for 1 cycle with `rmux_sel=1`, `alu_op=0`.
- LW with `mem_ready` low for 3 MEM cycles -> `mem_req=1`, `mem_sel_data=1`, `mem_we=0` held for 4 cycles; WB with `dmux_sel=1`; 8 cycles total.
- BEQ with `alu_zero=1`, then with `alu_zero=0` -> `pc_wren` with `pc_control=1` once, then no `pc_wren`; 3 cycles each.
- Opcode 111111 -> TRAP after DECODE, `trap=1`, no strobes for 20 cycles; `rst` pulse -> IDLE, `trap=0`.
- `MAX_WAIT=4`, `mem_ready` stuck at 0 in FETCH -> TRAP after 4 wait cycles, `mem_req` deasserts.
- `rst` asserted mid-MEM of SW -> `mem_req` drops in the same cycle; with `MULTICYCLE_CTRL_PERF_EN`, both counters read 0.
